// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NCH prescaled up-counters with compare, one-shot mode,
// sticky match flags, a combined IRQ and per-channel registered match pulses.
module apb_timer_mc #(
   parameter int NCH = 4,
   parameter int CW  = 32,
   parameter int PW  = 16
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             PSEL,
   input  logic [19:2]      PADDR,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [31:0]      PWDATA,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   output logic             IRQ,
   output logic [NCH-1:0]   MATCH_P
);

   localparam logic [31:0] BAD_RD = 32'hDEADBEEF;

   logic [CW-1:0]  cnt_q [NCH];
   logic [CW-1:0]  cnt_d [NCH];
   logic [PW-1:0]  pre_q [NCH];
   logic [PW-1:0]  pre_d [NCH];
   logic [CW-1:0]  cmp_q [NCH];
   logic [CW-1:0]  cmp_d [NCH];
   logic [PW-1:0]  psc_q [NCH];
   logic [PW-1:0]  psc_d [NCH];
   logic [2:0]     ctrl_q [NCH];
   logic [2:0]     ctrl_d [NCH];
   logic [NCH-1:0] match_q, match_d;
   logic [NCH-1:0] match_p_q, match_p_d;
   logic [NCH-1:0] tick, hit, wr_ch, irq_en;

   logic [2:0] ch_idx, reg_idx;
   logic       wr_en;
   logic       unused_bits;

   assign ch_idx      = PADDR[7:5];
   assign reg_idx     = PADDR[4:2];
   assign wr_en       = PSEL & PWRITE & PENABLE;
   assign unused_bits = ^{PADDR[19:8], PWDATA};

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         psc_d[i]     = psc_q[i];
         cnt_d[i]     = cnt_q[i];
         pre_d[i]     = pre_q[i];
         cmp_d[i]     = cmp_q[i];
         ctrl_d[i]    = ctrl_q[i];
         match_d[i]   = match_q[i];
         irq_en[i]    = ctrl_q[i][2];
         wr_ch[i]     = wr_en && (ch_idx == 3'(i));
         tick[i]      = ctrl_q[i][0] && (psc_q[i] == pre_q[i]);
         // A CNT write in the tick cycle overrides the counter, so no compare happens then.
         hit[i]       = tick[i] && (cnt_q[i] == cmp_q[i]) && !(wr_ch[i] && reg_idx == 3'd0);
         match_p_d[i] = hit[i];

         if (ctrl_q[i][0])
            psc_d[i] = tick[i] ? '0 : psc_q[i] + PW'(1);
         if (tick[i])
            cnt_d[i] = (cnt_q[i] == cmp_q[i]) ? '0 : cnt_q[i] + CW'(1);
         if (hit[i]) begin
            match_d[i] = 1'b1;
            if (ctrl_q[i][1])
               ctrl_d[i][0] = 1'b0;
         end

         if (wr_ch[i]) begin
            case (reg_idx)
               3'd0: begin
                  cnt_d[i] = PWDATA[CW-1:0];
                  psc_d[i] = '0;
               end
               3'd1: begin
                  pre_d[i] = PWDATA[PW-1:0];
                  psc_d[i] = '0;
               end
               3'd2: cmp_d[i] = PWDATA[CW-1:0];
               3'd3: begin
                  ctrl_d[i] = PWDATA[2:0];
                  if (!ctrl_q[i][0] && PWDATA[0])
                     psc_d[i] = '0;
               end
               3'd4: if (PWDATA[0] && !hit[i]) match_d[i] = 1'b0;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]  <= '0;
            pre_q[i]  <= '0;
            cmp_q[i]  <= '0;
            psc_q[i]  <= '0;
            ctrl_q[i] <= '0;
         end
         match_q   <= '0;
         match_p_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            pre_q[i]  <= pre_d[i];
            cmp_q[i]  <= cmp_d[i];
            psc_q[i]  <= psc_d[i];
            ctrl_q[i] <= ctrl_d[i];
         end
         match_q   <= match_d;
         match_p_q <= match_p_d;
      end
   end

   // Unmapped channels and register offsets read a recognisable poison value.
   always_comb begin
      PRDATA = BAD_RD;
      for (int i = 0; i < NCH; i++) begin
         if (ch_idx == 3'(i)) begin
            case (reg_idx)
               3'd0:    PRDATA = 32'(cnt_q[i]);
               3'd1:    PRDATA = 32'(pre_q[i]);
               3'd2:    PRDATA = 32'(cmp_q[i]);
               3'd3:    PRDATA = {29'b0, ctrl_q[i]};
               3'd4:    PRDATA = {31'b0, match_q[i]};
               default: PRDATA = BAD_RD;
            endcase
         end
      end
   end

   assign PREADY  = 1'b1;
   assign IRQ     = |(match_q & irq_en);
   assign MATCH_P = match_p_q;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed bench for apb_timer_mc (NCH=4, CW=8, PW=16) with immediate-assertion checks.
module tb_apb_timer_mc;

   logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
   logic [19:2] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, IRQ;
   logic [3:0]  MATCH_P;

   int errors = 0;
   int checks = 0;
   logic seen;

   apb_timer_mc #(.NCH(4), .CW(8), .PW(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .IRQ(IRQ), .MATCH_P(MATCH_P)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
      PADDR = a[19:2]; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      PADDR = a[19:2];
      #1;
      check(tag, PRDATA, exp);
   endtask

   initial begin
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      #12;
      check("rst_irq", 32'(IRQ), 32'h0);
      check("rst_matchp", 32'(MATCH_P), 32'h0);
      check("rst_pready", 32'(PREADY), 32'h1);
      #5 PRESETn = 1'b1;
      step();

      rd("rst_cnt0", 32'h00, 32'h0);
      rd("rst_pre0", 32'h04, 32'h0);
      rd("rst_cmp0", 32'h08, 32'h0);
      step();
      rd("rst_ctrl0", 32'h0C, 32'h0);
      rd("rst_stat0", 32'h10, 32'h0);
      rd("rsvd_0x14", 32'h14, 32'hDEADBEEF);
      step();
      rd("rsvd_0x1c", 32'h1C, 32'hDEADBEEF);
      rd("ch4_cnt", 32'h80, 32'hDEADBEEF);
      wr(32'h80, 32'h77);
      rd("ch4_wr_alias", 32'h00, 32'h0);

      // Channel 0: PRE=0, CMP=3, periodic
      wr(32'h08, 32'h3);
      wr(32'h0C, 32'h1);
      rd("c0_cnt_t0", 32'h00, 32'h0);
      step(); rd("c0_cnt_t1", 32'h00, 32'h1);
      step(); rd("c0_cnt_t2", 32'h00, 32'h2);
      step(); rd("c0_cnt_t3", 32'h00, 32'h3);
      check("c0_nopulse_t3", 32'(MATCH_P), 32'h0);
      step(); rd("c0_cnt_wrap", 32'h00, 32'h0);
      check("c0_pulse1", 32'(MATCH_P), 32'h1);
      rd("c0_stat", 32'h10, 32'h1);
      check("c0_irq_masked", 32'(IRQ), 32'h0);
      step(); check("c0_pulse_end", 32'(MATCH_P), 32'h0);
      repeat (3) step();
      check("c0_pulse2", 32'(MATCH_P), 32'h1);
      wr(32'h0C, 32'h0);
      wr(32'h10, 32'h1);
      rd("c0_stat_w1c", 32'h10, 32'h0);

      // Channel 1: PRE=2, CMP=1, one-shot
      wr(32'h24, 32'h2);
      wr(32'h28, 32'h1);
      wr(32'h2C, 32'h3);
      repeat (5) step();
      check("c1_nopulse_t5", 32'(MATCH_P), 32'h0);
      rd("c1_cnt_t5", 32'h20, 32'h1);
      step();
      check("c1_pulse_t6", 32'(MATCH_P), 32'h2);
      rd("c1_ctrl_auto", 32'h2C, 32'h2);
      rd("c1_cnt_t6", 32'h20, 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         seen = seen | MATCH_P[1];
      end
      check("c1_single_pulse", 32'(seen), 32'h0);
      rd("c1_cnt_hold", 32'h20, 32'h0);
      rd("c1_stat", 32'h30, 32'h1);

      // Channel 2: CMP=0, PRE=0, IRQEN
      wr(32'h4C, 32'h5);
      check("c2_irq_pre", 32'(IRQ), 32'h0);
      step();
      check("c2_irq_set", 32'(IRQ), 32'h1);
      check("c2_pulse", 32'(MATCH_P), 32'h4);
      wr(32'h50, 32'h1);
      rd("c2_w1c_vs_match", 32'h50, 32'h1);
      check("c2_irq_held", 32'(IRQ), 32'h1);
      wr(32'h4C, 32'h1);
      check("c2_irq_masked", 32'(IRQ), 32'h0);
      rd("c2_stat_kept", 32'h50, 32'h1);
      wr(32'h40, 32'h0);
      check("c2_cntwr_nocmp", 32'(MATCH_P), 32'h0);
      step();
      check("c2_pulse_resume", 32'(MATCH_P), 32'h4);
      wr(32'h4C, 32'h0);
      step();
      check("c2_stopped", 32'(MATCH_P), 32'h0);
      wr(32'h50, 32'h0);
      rd("c2_w0_noeffect", 32'h50, 32'h1);
      wr(32'h50, 32'h1);
      rd("c2_w1_clears", 32'h50, 32'h0);

      // Channel 3: CNT=0xFF wraps, CMP=0x10
      wr(32'h60, 32'hFF);
      wr(32'h68, 32'h10);
      wr(32'h6C, 32'h1);
      rd("c3_cnt_ff", 32'h60, 32'hFF);
      step(); rd("c3_wrap", 32'h60, 32'h00);
      repeat (16) step();
      rd("c3_cnt_cmp", 32'h60, 32'h10);
      check("c3_nopulse", 32'(MATCH_P), 32'h0);
      step();
      check("c3_pulse", 32'(MATCH_P), 32'h8);
      rd("c3_cnt_zero", 32'h60, 32'h00);
      wr(32'h60, 32'h05);
      rd("c3_cnt_wr", 32'h60, 32'h05);
      step(); rd("c3_cnt_6", 32'h60, 32'h06);
      step(); rd("c3_cnt_7", 32'h60, 32'h07);

      // Channel 0 re-armed with IRQEN alongside channel 3, then async reset
      wr(32'h00, 32'h0);
      wr(32'h04, 32'h1);
      wr(32'h08, 32'h2);
      wr(32'h0C, 32'h5);
      repeat (5) step();
      check("c0b_nopulse_t5", 32'(MATCH_P[0]), 32'h0);
      step();
      check("c0b_pulse_t6", 32'(MATCH_P[0]), 32'h1);
      check("c0b_irq", 32'(IRQ), 32'h1);
      #2 PRESETn = 1'b0;
      #1;
      check("arst_irq", 32'(IRQ), 32'h0);
      check("arst_matchp", 32'(MATCH_P), 32'h0);
      rd("arst_ctrl0", 32'h0C, 32'h0);
      rd("arst_cnt3", 32'h60, 32'h0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         seen = seen | (|MATCH_P) | IRQ;
      end
      check("post_rst_idle", 32'(seen), 32'h0);
      rd("post_rst_cnt0", 32'h00, 32'h0);
      rd("post_rst_ctrl3", 32'h6C, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
